// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA frame scheduler.
package vga_pkg;

  localparam int SCHED_N_REQ  = 3;
  localparam int SCHED_DATA_W = 16;
  localparam int FRAME_CNT_W  = 16;
  localparam int GRANT_W      = 2;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    COMMIT = 2'd1,
    BLANK  = 2'd2
  } sched_state_e;

  // Next requester index in the round-robin ring (wraps after the last one).
  function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] idx);
    return (idx == GRANT_W'(SCHED_N_REQ - 1)) ? '0 : idx + GRANT_W'(1);
  endfunction

endpackage

// File: rtl/vga_frame_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starting just after last_grant.
module rr_arbiter
  import vga_pkg::*;
(
  input  logic [SCHED_N_REQ-1:0] req,
  input  logic [GRANT_W-1:0]     last_grant,
  output logic [SCHED_N_REQ-1:0] grant
);

  logic [GRANT_W-1:0] idx;
  logic               found;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = rr_next(last_grant);
    for (int k = 0; k < SCHED_N_REQ; k++) begin
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
      idx = rr_next(idx);
    end
  end

endmodule

// File: rtl/vga_frame_sched.sv
// Double-buffered per-slot update scheduler; shadow words commit to active_data on vblank.
// Optional frame counter enabled by defining VGA_SCHED_FRAME_CNT_EN.
module vga_frame_sched
  import vga_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     vblnk,
  input  logic [SCHED_N_REQ-1:0]                   req_valid,
  input  logic [SCHED_N_REQ-1:0][SCHED_DATA_W-1:0] req_data,
  output logic [SCHED_N_REQ-1:0]                   req_ready,
  output logic [SCHED_N_REQ-1:0][SCHED_DATA_W-1:0] active_data,
  output logic                                     frame_tick,
  output logic [FRAME_CNT_W-1:0]                   frame_cnt,
  output logic                                     busy
);

  sched_state_e                             state, state_nxt;
  logic                                     vblnk_d;
  logic                                     vblnk_rise;
  logic                                     arb_en;
  logic [GRANT_W-1:0]                       last_grant;
  logic [GRANT_W-1:0]                       grant_idx;
  logic [SCHED_N_REQ-1:0]                   arb_req;
  logic [SCHED_N_REQ-1:0]                   grant;
  logic [SCHED_N_REQ-1:0][SCHED_DATA_W-1:0] shadow;
  logic [SCHED_N_REQ-1:0]                   dirty;

  assign vblnk_rise = vblnk & ~vblnk_d;

  always_comb begin
    state_nxt = state;
    arb_en    = 1'b1;
    unique case (state)
      ACTIVE: if (vblnk_rise) state_nxt = COMMIT;
      COMMIT: begin
        arb_en    = 1'b0;
        state_nxt = BLANK;
      end
      BLANK:  if (!vblnk) state_nxt = ACTIVE;
      default: state_nxt = ACTIVE;
    endcase
  end

  assign arb_req = req_valid & {SCHED_N_REQ{arb_en}};

  rr_arbiter u_rr_arbiter (
    .req        (arb_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req_ready = grant;
  assign busy      = |dirty;

  always_comb begin
    grant_idx = last_grant;
    for (int i = 0; i < SCHED_N_REQ; i++) begin
      if (grant[i]) grant_idx = GRANT_W'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACTIVE;
      vblnk_d     <= 1'b1;  // vblnk held high across reset must not look like a rise
      last_grant  <= GRANT_W'(SCHED_N_REQ - 1);
      // NOTE: the shadow/active word arrays are reset too, since draw logic reads them straight away.
      shadow      <= '0;
      active_data <= '0;
      dirty       <= '0;
      frame_tick  <= 1'b0;
    end else begin
      state      <= state_nxt;
      vblnk_d    <= vblnk;
      frame_tick <= (state == COMMIT);
      if (state == COMMIT) begin
        for (int i = 0; i < SCHED_N_REQ; i++) begin
          if (dirty[i]) active_data[i] <= shadow[i];
        end
        dirty <= '0;
      end
      // No grant is issued in COMMIT, so these never collide with the dirty clear.
      for (int i = 0; i < SCHED_N_REQ; i++) begin
        if (grant[i]) begin
          shadow[i] <= req_data[i];
          dirty[i]  <= 1'b1;
        end
      end
      if (|grant) last_grant <= grant_idx;
    end
  end

`ifdef VGA_SCHED_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (state == COMMIT) begin
      frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_frame_sched.sv
// Randomized + directed bench for vga_frame_sched against a cycle-level behavioural model.
module tb_vga_frame_sched;

  logic             clk = 1'b0;
  logic             rst;
  logic             vblnk;
  logic [2:0]       req_valid;
  logic [2:0][15:0] req_data;
  logic [2:0]       req_ready;
  logic [2:0][15:0] active_data;
  logic             frame_tick;
  logic [15:0]      frame_cnt;
  logic             busy;

  vga_frame_sched dut (
    .clk         (clk),
    .rst         (rst),
    .vblnk       (vblnk),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .active_data (active_data),
    .frame_tick  (frame_tick),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int tick_count = 0;

  // Behavioural model: phase 0 = display, 1 = commit cycle, 2 = blanking.
  int               m_phase;
  bit               m_vd;
  int               m_last;
  logic [2:0][15:0] m_shadow;
  logic [2:0][15:0] m_active;
  bit   [2:0]       m_dirty;
  bit               m_tick;
  logic [15:0]      m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_vd     = 1'b1;
    m_last   = 2;
    m_shadow = '0;
    m_active = '0;
    m_dirty  = '0;
    m_tick   = 1'b0;
    m_cnt    = '0;
  endtask

  // One clock cycle: drive inputs, compare everything against the model, then advance the model.
  task automatic step(input logic r, input logic vb, input logic [2:0] v,
                      input logic [2:0][15:0] d, output logic [2:0] rdy_seen);
    int g;
    logic [2:0] exp_rdy;
    bit rise;
    @(negedge clk);
    rst = r; vblnk = vb; req_valid = v; req_data = d;
    #1;
    g = -1;
    if (m_phase != 1) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (m_last + 1 + k) % 3;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_rdy = (g < 0) ? 3'b000 : 3'(1 << g);
    rdy_seen = req_ready;
    if (frame_tick === 1'b1) tick_count++;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("busy", 64'(busy), 64'(m_dirty != 0));
    check("active_data", 64'(active_data), 64'(m_active));
    check("frame_tick", 64'(frame_tick), 64'(m_tick));
    check("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      rise   = vb && !m_vd;
      m_tick = (m_phase == 1);
      if (m_phase == 1) begin
        for (int i = 0; i < 3; i++) if (m_dirty[i]) m_active[i] = m_shadow[i];
        m_dirty = '0;
`ifdef VGA_SCHED_FRAME_CNT_EN
        m_cnt = m_cnt + 16'd1;
`endif
      end
      if (g >= 0) begin
        m_shadow[g] = d[g];
        m_dirty[g]  = 1'b1;
        m_last      = g;
      end
      case (m_phase)
        0:       m_phase = rise ? 1 : 0;
        1:       m_phase = 2;
        default: m_phase = vb ? 2 : 0;
      endcase
      m_vd = vb;
    end
  endtask

  logic [2:0]       rdy;
  logic [2:0][15:0] d0;
  logic [2:0][15:0] d1;
  logic [2:0][15:0] dr;
  logic             vb_r;
  int               base;

  initial begin
    d0 = '0;
    d1 = {16'h3333, 16'h2222, 16'h1111};
    rst = 1'b1; vblnk = 1'b0; req_valid = '0; req_data = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // Idle after reset: nothing moves.
    base = tick_count;
    step(1'b1, 1'b0, 3'b000, d0, rdy);
    repeat (6) step(1'b0, 1'b0, 3'b000, d0, rdy);
    #1;
    check("idle_active", 64'(active_data), 64'h0);
    check("idle_busy", 64'(busy), 64'h0);
    check("idle_ticks", 64'(tick_count - base), 64'h0);

    // All three request together: round-robin 0,1,2, then one commit.
    step(1'b0, 1'b0, 3'b111, d1, rdy); check("rr_first", 64'(rdy), 64'h1);
    step(1'b0, 1'b0, 3'b111, d1, rdy); check("rr_second", 64'(rdy), 64'h2);
    step(1'b0, 1'b0, 3'b111, d1, rdy); check("rr_third", 64'(rdy), 64'h4);
    base = tick_count;
    step(1'b0, 1'b0, 3'b000, d1, rdy);
    step(1'b0, 1'b1, 3'b000, d1, rdy);
    step(1'b0, 1'b1, 3'b000, d1, rdy);
    step(1'b0, 1'b0, 3'b000, d1, rdy);
    step(1'b0, 1'b0, 3'b000, d1, rdy);
    #1;
    check("rr_commit_data", 64'(active_data), 64'(d1));
    check("rr_commit_busy", 64'(busy), 64'h0);
    check("rr_commit_ticks", 64'(tick_count - base), 64'h1);

    // Player writes twice before vblank: last writer wins.
    step(1'b0, 1'b0, 3'b010, {16'h0, 16'h00A1, 16'h0}, rdy);
    step(1'b0, 1'b0, 3'b010, {16'h0, 16'h00B2, 16'h0}, rdy);
    step(1'b0, 1'b1, 3'b000, d0, rdy);
    step(1'b0, 1'b1, 3'b000, d0, rdy);
    step(1'b0, 1'b0, 3'b000, d0, rdy);
    #1;
    check("lww_data", 64'(active_data), 64'({16'h3333, 16'h00B2, 16'h1111}));

    // Valid held across the COMMIT cycle: refused there, accepted next, shown next frame.
    step(1'b0, 1'b1, 3'b000, d0, rdy);
    step(1'b0, 1'b1, 3'b010, {16'h0, 16'h5555, 16'h0}, rdy); check("commit_no_ready", 64'(rdy), 64'h0);
    step(1'b0, 1'b1, 3'b010, {16'h0, 16'h5555, 16'h0}, rdy); check("blank_ready", 64'(rdy), 64'h2);
    #1;
    check("not_this_frame", 64'(active_data[1]), 64'h00B2);
    step(1'b0, 1'b0, 3'b000, d0, rdy);
    step(1'b0, 1'b1, 3'b000, d0, rdy);
    step(1'b0, 1'b1, 3'b000, d0, rdy);
    step(1'b0, 1'b0, 3'b000, d0, rdy);
    #1;
    check("next_frame", 64'(active_data[1]), 64'h5555);

    // Reset released with vblnk high: no tick until vblnk falls and rises.
    base = tick_count;
    step(1'b1, 1'b1, 3'b000, d0, rdy);
    repeat (5) step(1'b0, 1'b1, 3'b000, d0, rdy);
    check("rst_vblnk_quiet", 64'(tick_count - base), 64'h0);
    step(1'b0, 1'b0, 3'b000, d0, rdy);
    step(1'b0, 1'b1, 3'b000, d0, rdy);
    step(1'b0, 1'b1, 3'b000, d0, rdy);
    step(1'b0, 1'b1, 3'b000, d0, rdy);
    check("rst_vblnk_tick", 64'(tick_count - base), 64'h1);

    // Randomized traffic, vblank toggling and occasional reset.
    vb_r = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) vb_r = ~vb_r;
      for (int i = 0; i < 3; i++) dr[i] = 16'($urandom);
      step(($urandom_range(0, 299) == 0), vb_r, 3'($urandom), dr, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
